// File: rtl/jk_pkg.sv
// Shared types for the JK command sequencer: op encodings, FSM state,
// and the JK next-state helper used by the Q predictor.
package jk_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_RST  = 2'b01,
    OP_SET  = 2'b10,
    OP_TGL  = 2'b11
  } jk_op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } jk_state_e;

  function automatic logic jk_next(
    input logic       q,
    input logic [1:0] jk
  );
    logic r;
    r = q;
    unique case (jk)
      OP_HOLD: r = q;
      OP_RST:  r = 1'b0;
      OP_SET:  r = 1'b1;
      OP_TGL:  r = ~q;
      default: r = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_cmd_sequencer_if.sv
// Command handshake bundle between a producer and the JK sequencer.
interface jk_cmd_sequencer_if #(
  parameter int REP_W = 4
);
  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic [REP_W-1:0] cmd_rep;
  logic             cmd_ready;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_rep,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_rep,
    output cmd_ready
  );
endinterface

// File: rtl/jk_cmd_fifo.sv
// Power-of-two command FIFO; pointers wrap naturally, level counts
// occupancy and is unchanged on a simultaneous push and pop.
module jk_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic [LW-1:0] o_level,
  output logic          o_full,
  output logic          o_empty
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [LW-1:0] r_level;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_data  = r_mem[r_rd];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Queues JK commands and replays each on registered J/K for rep+1
// cycles, predicting the downstream flip-flop Q as it goes.
module jk_cmd_sequencer
  import jk_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int REP_W = 4,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  jk_cmd_sequencer_if.slave cmd,
  output logic            J,
  output logic            K,
  output logic            busy,
  output logic            cmd_done,
  output logic            q_model,
  output logic [LW-1:0]   level
);

  localparam int W = 2 + REP_W;

  logic [W-1:0]     w_head;
  logic [1:0]       w_hop;
  logic [REP_W-1:0] w_hrep;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_last;
  logic [LW-1:0]    w_level;

  jk_state_e        r_state;
  logic [1:0]       r_op;
  logic [REP_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_q;

  assign cmd.cmd_ready = !w_full;
  assign w_push = cmd.cmd_valid && !w_full;

  jk_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  ({cmd.cmd_op, cmd.cmd_rep}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign {w_hop, w_hrep} = w_head;

  // Pop in IDLE or on the last issue cycle so commands chain gap-free
  assign w_last = (r_state == ISSUE) && (r_cnt == '0);
  assign w_pop  = !w_empty && ((r_state == IDLE) || w_last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_op    <= OP_HOLD;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_q     <= 1'b0;
    end else begin
      r_q <= jk_next(r_q, r_op);
      if (w_pop) begin
        r_state <= ISSUE;
        r_op    <= w_hop;
        r_cnt   <= w_hrep;
        r_busy  <= 1'b1;
        r_done  <= (w_hrep == '0);
      end else if ((r_state == IDLE) || w_last) begin
        r_state <= IDLE;
        r_op    <= OP_HOLD;
        r_cnt   <= '0;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        r_cnt  <= r_cnt - 1'b1;
        r_done <= (r_cnt == REP_W'(1));
      end
    end
  end

  assign {J, K}   = r_op;
  assign busy     = r_busy;
  assign cmd_done = r_done;
  assign q_model  = r_q;
  assign level    = w_level;

endmodule
